// File: rtl/ysyx_25050136_scoreboard_if.sv
// ID/EX/WB bundle between the pipeline and the register-hazard scoreboard.
// Master drives instruction, bypass and retire information; slave returns issue and bypass selects.
interface ysyx_25050136_scoreboard_if #(
  parameter int ADDR_WIDTH = 4
) ();
  logic                  id_valid_i;
  logic [ADDR_WIDTH-1:0] id_rs1_i;
  logic [ADDR_WIDTH-1:0] id_rs2_i;
  logic                  id_rs1_en_i;
  logic                  id_rs2_en_i;
  logic [ADDR_WIDTH-1:0] id_rd_i;
  logic                  id_rd_en_i;
  logic                  ex_ready_i;
  logic                  flush_i;
  logic                  issue_o;
  logic                  id_ready_o;
  logic                  ex_wen_i;
  logic                  ex_wvalid_i;
  logic [ADDR_WIDTH-1:0] ex_waddr_i;
  logic [31:0]           ex_wdata_i;
  logic                  wb_valid_i;
  logic [ADDR_WIDTH-1:0] wb_rd_i;
  logic                  wb_rd_en_i;
  logic                  fwd1_en_o;
  logic                  fwd2_en_o;
  logic [31:0]           fwd1_data_o;
  logic [31:0]           fwd2_data_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_en_i, id_rs2_en_i, id_rd_i, id_rd_en_i,
    output ex_ready_i, flush_i, ex_wen_i, ex_wvalid_i, ex_waddr_i, ex_wdata_i,
    output wb_valid_i, wb_rd_i, wb_rd_en_i,
    input  issue_o, id_ready_o, fwd1_en_o, fwd2_en_o, fwd1_data_o, fwd2_data_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_en_i, id_rs2_en_i, id_rd_i, id_rd_en_i,
    input  ex_ready_i, flush_i, ex_wen_i, ex_wvalid_i, ex_waddr_i, ex_wdata_i,
    input  wb_valid_i, wb_rd_i, wb_rd_en_i,
    output issue_o, id_ready_o, fwd1_en_o, fwd2_en_o, fwd1_data_o, fwd2_data_o
  );
endinterface

// File: rtl/ysyx_25050136_scoreboard.sv
// Register-hazard scoreboard between ID and EX: per-GPR in-flight write counters, RAW/WAW stall, EX bypass select.
// Optional SCOREBOARD_PERF_EN adds a wrapping stall-cycle counter on stall_cnt_o.
module ysyx_25050136_scoreboard #(
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  ysyx_25050136_scoreboard_if.slave    sb,
  output logic                         err_o
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]                  stall_cnt_o
`endif
);

  localparam int                   NREG    = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q [NREG];
  logic [CNT_WIDTH-1:0] cnt_d [NREG];
  logic [NREG-1:0]      uflow;
  logic                 err_q;
  logic                 err_d;

  logic [ADDR_WIDTH-1:0] src_idx [2];
  logic [1:0]            src_en;
  logic [1:0]            src_fwd;
  logic [1:0]            src_block;

  logic rd_full;
  logic issue;
  logic issue_fire;
  logic retire;

  assign src_idx[0] = sb.id_rs1_i;
  assign src_idx[1] = sb.id_rs2_i;
  assign src_en[0]  = sb.id_rs1_en_i;
  assign src_en[1]  = sb.id_rs2_en_i;

  // A busy source is forwardable only when exactly one write is pending and EX already holds its value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic busy;
    logic ex_hit;
    assign busy          = src_en[gi] & (src_idx[gi] != '0) & (cnt_q[src_idx[gi]] != '0);
    assign ex_hit        = sb.ex_wen_i & sb.ex_wvalid_i & (sb.ex_waddr_i == src_idx[gi]);
    assign src_fwd[gi]   = busy & (cnt_q[src_idx[gi]] == CNT_ONE) & ex_hit;
    assign src_block[gi] = busy & ~src_fwd[gi];
  end

  assign rd_full    = sb.id_rd_en_i & (sb.id_rd_i != '0) & (cnt_q[sb.id_rd_i] == CNT_MAX);
  assign issue      = sb.id_valid_i & ~sb.flush_i & ~(|src_block) & ~rd_full;
  assign issue_fire = issue & sb.ex_ready_i;
  assign retire     = sb.wb_valid_i & sb.wb_rd_en_i;

  assign sb.issue_o     = issue;
  assign sb.id_ready_o  = issue_fire | sb.flush_i;
  assign sb.fwd1_en_o   = issue & src_fwd[0];
  assign sb.fwd2_en_o   = issue & src_fwd[1];
  assign sb.fwd1_data_o = sb.ex_wdata_i;
  assign sb.fwd2_data_o = sb.ex_wdata_i;

  // x0 is never tracked; same-cycle issue and retire of one register cancel out.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
    if (gi == 0) begin : g_x0
      assign cnt_d[gi] = '0;
      assign uflow[gi] = 1'b0;
    end else begin : g_reg
      logic inc;
      logic dec;
      assign inc = issue_fire & sb.id_rd_en_i & (sb.id_rd_i == ADDR_WIDTH'(gi));
      assign dec = retire & (sb.wb_rd_i == ADDR_WIDTH'(gi));
      assign uflow[gi] = dec & ~inc & (cnt_q[gi] == '0);
      assign cnt_d[gi] = (inc & ~dec)                        ? cnt_q[gi] + CNT_ONE :
                         (dec & ~inc & (cnt_q[gi] != '0))    ? cnt_q[gi] - CNT_ONE :
                                                               cnt_q[gi];
    end
  end

  assign err_d = err_q | (|uflow);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  assign stall_cnt_d = (sb.id_valid_i & ~sb.flush_i & ~issue) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_25050136_scoreboard.sv
// Directed bench for the register-hazard scoreboard: one-cycle vector table plus reset/perf sequences.
module tb_ysyx_25050136_scoreboard;

  logic clk;
  logic reset;
  logic err_o;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  ysyx_25050136_scoreboard_if #(.ADDR_WIDTH(4)) sb_if ();

  ysyx_25050136_scoreboard #(.ADDR_WIDTH(4), .CNT_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave),
    .err_o (err_o)
`ifdef SCOREBOARD_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [3:0]  rs1;
    logic        rs1_en;
    logic [3:0]  rs2;
    logic        rs2_en;
    logic [3:0]  rd;
    logic        rd_en;
    logic        rdy;
    logic        flush;
    logic        wen;
    logic        wvalid;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        wbv;
    logic [3:0]  wbrd;
    logic        wben;
    logic        e_issue;
    logic        e_idrdy;
    logic        e_f1;
    logic        e_f2;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input int vld, input int rs1, input int rs1_en, input int rs2, input int rs2_en,
                              input int rd, input int rd_en, input int rdy, input int flush,
                              input int wen, input int wvalid, input int waddr, input logic [31:0] wdata,
                              input int wbv, input int wbrd, input int wben,
                              input int e_issue, input int e_idrdy, input int e_f1, input int e_f2, input int e_err);
    vec_t v;
    v.vld = (vld != 0);       v.rs1 = 4'(rs1);     v.rs1_en = (rs1_en != 0);
    v.rs2 = 4'(rs2);          v.rs2_en = (rs2_en != 0);
    v.rd = 4'(rd);            v.rd_en = (rd_en != 0);
    v.rdy = (rdy != 0);       v.flush = (flush != 0);
    v.wen = (wen != 0);       v.wvalid = (wvalid != 0); v.waddr = 4'(waddr); v.wdata = wdata;
    v.wbv = (wbv != 0);       v.wbrd = 4'(wbrd);   v.wben = (wben != 0);
    v.e_issue = (e_issue != 0); v.e_idrdy = (e_idrdy != 0);
    v.e_f1 = (e_f1 != 0);     v.e_f2 = (e_f2 != 0); v.e_err = (e_err != 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb_if.id_valid_i  = v.vld;
    sb_if.id_rs1_i    = v.rs1;
    sb_if.id_rs1_en_i = v.rs1_en;
    sb_if.id_rs2_i    = v.rs2;
    sb_if.id_rs2_en_i = v.rs2_en;
    sb_if.id_rd_i     = v.rd;
    sb_if.id_rd_en_i  = v.rd_en;
    sb_if.ex_ready_i  = v.rdy;
    sb_if.flush_i     = v.flush;
    sb_if.ex_wen_i    = v.wen;
    sb_if.ex_wvalid_i = v.wvalid;
    sb_if.ex_waddr_i  = v.waddr;
    sb_if.ex_wdata_i  = v.wdata;
    sb_if.wb_valid_i  = v.wbv;
    sb_if.wb_rd_i     = v.wbrd;
    sb_if.wb_rd_en_i  = v.wben;
  endtask

  vec_t idle;
  vec_t vecs [21];

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0, 0,0,0,32'h0, 0,0,0, 0,0,0,0,0);
    drive(idle);
    reset = 1'b0;

    // vld rs1 e1 rs2 e2 rd rde rdy fl | wen wv wa wdata | wbv wbrd wbe | issue idrdy f1 f2 err
    vecs[0]  = mk(1,3,1,4,1,5,1,1,0, 0,0,0,32'h0,         0,0,0, 1,1,0,0,0);
    vecs[1]  = mk(1,5,1,0,0,6,1,1,0, 1,0,5,32'h11,        0,0,0, 0,0,0,0,0);
    vecs[2]  = mk(1,5,1,0,0,6,1,1,0, 1,0,5,32'h11,        1,5,1, 0,0,0,0,0);
    vecs[3]  = mk(1,5,1,0,0,6,1,1,0, 0,0,0,32'h0,         0,0,0, 1,1,0,0,0);
    vecs[4]  = mk(1,0,0,0,0,1,1,1,0, 0,0,0,32'h0,         0,0,0, 1,1,0,0,0);
    vecs[5]  = mk(1,0,1,1,1,0,1,1,0, 1,1,1,32'h8000_0004, 0,0,0, 1,1,0,1,0);
    vecs[6]  = mk(1,0,1,1,1,0,1,0,0, 1,1,1,32'h8000_0004, 0,0,0, 1,0,0,1,0);
    vecs[7]  = mk(1,1,1,0,0,0,0,1,0, 1,1,2,32'h22,        0,0,0, 0,0,0,0,0);
    vecs[8]  = mk(1,0,0,0,0,7,1,1,0, 0,0,0,32'h0,         0,0,0, 1,1,0,0,0);
    vecs[9]  = mk(1,0,0,0,0,7,1,1,0, 0,0,0,32'h0,         0,0,0, 1,1,0,0,0);
    vecs[10] = mk(1,0,0,0,0,7,1,1,0, 0,0,0,32'h0,         0,0,0, 1,1,0,0,0);
    vecs[11] = mk(1,0,0,0,0,7,1,1,0, 0,0,0,32'h0,         0,0,0, 0,0,0,0,0);
    vecs[12] = mk(1,0,0,0,0,7,1,1,0, 0,0,0,32'h0,         1,7,1, 0,0,0,0,0);
    vecs[13] = mk(1,0,0,0,0,7,1,1,0, 0,0,0,32'h0,         1,7,1, 1,1,0,0,0);
    vecs[14] = mk(1,0,0,0,0,7,1,1,0, 0,0,0,32'h0,         0,0,0, 1,1,0,0,0);
    vecs[15] = mk(1,0,0,0,0,7,1,1,0, 0,0,0,32'h0,         0,0,0, 0,0,0,0,0);
    vecs[16] = mk(1,0,0,0,0,8,1,1,1, 0,0,0,32'h0,         0,0,0, 0,1,0,0,0);
    vecs[17] = mk(1,8,1,0,1,0,1,1,0, 0,0,0,32'h0,         1,0,1, 1,1,0,0,0);
    vecs[18] = mk(0,0,0,0,0,0,0,1,0, 0,0,0,32'h0,         1,9,1, 0,0,0,0,0);
    vecs[19] = mk(0,0,0,0,0,0,0,1,0, 0,0,0,32'h0,         0,0,0, 0,0,0,0,1);
    vecs[20] = mk(0,0,0,0,0,0,0,1,0, 0,0,0,32'h0,         1,3,0, 0,0,0,0,1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_err", {31'd0, err_o}, 32'd0);
`ifdef SCOREBOARD_PERF_EN
    chk("reset_stall_cnt", stall_cnt_o, 32'd0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_issue", i),    {31'd0, sb_if.issue_o},    {31'd0, vecs[i].e_issue});
      chk($sformatf("v%0d_id_ready", i), {31'd0, sb_if.id_ready_o}, {31'd0, vecs[i].e_idrdy});
      chk($sformatf("v%0d_fwd1_en", i),  {31'd0, sb_if.fwd1_en_o},  {31'd0, vecs[i].e_f1});
      chk($sformatf("v%0d_fwd2_en", i),  {31'd0, sb_if.fwd2_en_o},  {31'd0, vecs[i].e_f2});
      chk($sformatf("v%0d_fwd1_data", i), sb_if.fwd1_data_o, vecs[i].wdata);
      chk($sformatf("v%0d_fwd2_data", i), sb_if.fwd2_data_o, vecs[i].wdata);
      chk($sformatf("v%0d_err", i),      {31'd0, err_o},            {31'd0, vecs[i].e_err});
      $display("vec %0d: issue=%0b id_ready=%0b fwd1=%0b fwd2=%0b err=%0b",
               i, sb_if.issue_o, sb_if.id_ready_o, sb_if.fwd1_en_o, sb_if.fwd2_en_o, err_o);
      @(posedge clk);
      #1;
    end

`ifdef SCOREBOARD_PERF_EN
    // Stalls in vectors 1, 2, 7, 11, 12 and 15.
    chk("table_stall_cnt", stall_cnt_o, 32'd6);
`endif

    // Mid-stream asynchronous reset: rd=7 is full (cnt 3) and err is set.
    drive(mk(1,7,1,0,0,7,1,1,0, 0,0,0,32'h0, 0,0,0, 0,0,0,0,0));
    #2;
    chk("pre_reset_issue", {31'd0, sb_if.issue_o}, 32'd0);
    chk("pre_reset_err",   {31'd0, err_o},         32'd1);
    reset = 1'b0;
    #1;
    chk("async_reset_err",   {31'd0, err_o},         32'd0);
    chk("async_reset_issue", {31'd0, sb_if.issue_o}, 32'd1);
    $display("async reset: issue=%0b err=%0b", sb_if.issue_o, err_o);
    @(posedge clk);
    #1;
    drive(idle);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_err", {31'd0, err_o}, 32'd0);
    @(posedge clk);
    #1;

    // One issue to rd=2, then a dependent stalls four cycles.
    drive(mk(1,0,0,0,0,2,1,1,0, 0,0,0,32'h0, 0,0,0, 0,0,0,0,0));
    @(negedge clk);
    chk("perf_issue_rd2", {31'd0, sb_if.issue_o}, 32'd1);
    @(posedge clk);
    #1;
    drive(mk(1,2,1,0,0,0,0,1,0, 0,0,0,32'h0, 0,0,0, 0,0,0,0,0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("perf_stall%0d_issue", k), {31'd0, sb_if.issue_o}, 32'd0);
      $display("stall cycle %0d: issue=%0b", k, sb_if.issue_o);
      @(posedge clk);
      #1;
    end
    drive(idle);
    @(negedge clk);
`ifdef SCOREBOARD_PERF_EN
    chk("perf_stall_cnt", stall_cnt_o, 32'd4);
    $display("stall_cnt_o=%0d", stall_cnt_o);
`endif

    // Retire rd=2 (cnt 1): dependent issues next cycle, no error.
    drive(mk(0,0,0,0,0,0,0,1,0, 0,0,0,32'h0, 1,2,1, 0,0,0,0,0));
    @(posedge clk);
    #1;
    drive(mk(1,2,1,0,0,0,0,1,0, 0,0,0,32'h0, 0,0,0, 0,0,0,0,0));
    @(negedge clk);
    chk("retire_unblock_issue", {31'd0, sb_if.issue_o}, 32'd1);
    chk("retire_ok_err",        {31'd0, err_o},         32'd0);
    $display("after retire rd2: issue=%0b err=%0b", sb_if.issue_o, err_o);
    @(posedge clk);
    #1;
    drive(idle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
